xif_issue_initiator: RTL



---
 rtl/xif_issue_initiator.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/xif_issue_initiator.sv
// rtl/xif_issue_initiator.sv - eXtension-interface issue/commit/result initiator with ID scoreboard
module xif_issue_initiator #(
    parameter int X_ID_WIDTH      = 4,
    parameter int X_NUM_RS        = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [31:0]             cmd_instr_i,
    input  logic [32*X_NUM_RS-1:0]  cmd_rs_i,
    input  logic                    cmd_kill_i,
    output logic                    issue_valid_o,
    input  logic                    issue_ready_i,
    output logic [31:0]             issue_instr_o,
    output logic [X_ID_WIDTH-1:0]   issue_id_o,
    output logic [32*X_NUM_RS-1:0]  issue_rs_o,
    output logic [X_NUM_RS-1:0]     issue_rs_valid_o,
    input  logic                    issue_accept_i,
    input  logic                    issue_writeback_i,
    output logic                    commit_valid_o,
    output logic [X_ID_WIDTH-1:0]   commit_id_o,
    output logic                    commit_kill_o,
    input  logic                    result_valid_i,
    output logic                    result_ready_o,
    input  logic [X_ID_WIDTH-1:0]   result_id_i,
    input  logic [31:0]             result_data_i,
    input  logic [4:0]              result_rd_i,
    input  logic                    result_we_i,
    output logic                    rsp_valid_o,
    output logic [X_ID_WIDTH-1:0]   rsp_id_o,
    output logic [31:0]             rsp_data_o,
    output logic [4:0]              rsp_rd_o,
    output logic                    rsp_we_o,
    output logic                    rej_valid_o,
    output logic                    err_o,
    output logic [15:0]             issued_cnt_o,
    output logic [15:0]             retired_cnt_o
);

    localparam int NUM_IDS = 2 ** X_ID_WIDTH;
    localparam int CNT_W   = X_ID_WIDTH + 1;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_active;
    logic [31:0]               r_instr;
    logic [32*X_NUM_RS-1:0]    r_rs;
    logic                      r_kill;
    logic                      r_writeback;
    logic [X_ID_WIDTH-1:0]     r_next_id;
    logic [NUM_IDS-1:0]        r_pending;
    logic [CNT_W-1:0]          r_outstanding;
    logic                      r_commit_valid;
    logic [X_ID_WIDTH-1:0]     r_commit_id;
    logic                      r_commit_kill;
    logic                      r_rej_valid;
    logic                      r_rsp_valid;
    logic [X_ID_WIDTH-1:0]     r_rsp_id;
    logic [31:0]               r_rsp_data;
    logic [4:0]                r_rsp_rd;
    logic                      r_rsp_we;
    logic                      r_err;
    logic [15:0]               r_issued_cnt;
    logic [15:0]               r_retired_cnt;

    logic                      w_cmd_hs;
    logic                      w_issue_hs;
    logic                      w_set;
    logic                      w_res_hit;
    logic                      w_res_miss;
    logic [NUM_IDS-1:0]        w_set_mask;
    logic [NUM_IDS-1:0]        w_clr_mask;

    assign w_cmd_hs   = cmd_valid_i && cmd_ready_o;
    assign w_issue_hs = (r_state == S_ISSUE) && issue_ready_i;
    // Only accepted, non-killed instructions will ever return a result
    assign w_set      = w_issue_hs && issue_accept_i && !r_kill;
    assign w_res_hit  = result_valid_i && r_pending[result_id_i];
    assign w_res_miss = result_valid_i && !r_pending[result_id_i];

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic: one instruction in flight on the issue channel at a time
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_hs)      w_state_nxt = S_ISSUE;
            S_ISSUE: if (issue_ready_i) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs: r_active keeps cmd_ready_o low while in reset
    always_comb begin
        cmd_ready_o      = r_active && (r_state == S_IDLE) &&
                           (r_outstanding < CNT_W'(MAX_OUTSTANDING)) && !r_pending[r_next_id];
        issue_valid_o    = (r_state == S_ISSUE);
        issue_rs_valid_o = {X_NUM_RS{issue_valid_o}};
    end

    // Command holding register, ID allocation, commit/reject strobes, issue counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active       <= 1'b0;
            r_instr        <= '0;
            r_rs           <= '0;
            r_kill         <= 1'b0;
            r_writeback    <= 1'b0;
            r_next_id      <= '0;
            r_commit_valid <= 1'b0;
            r_commit_id    <= '0;
            r_commit_kill  <= 1'b0;
            r_rej_valid    <= 1'b0;
            r_issued_cnt   <= '0;
        end else begin
            r_active       <= 1'b1;
            r_commit_valid <= w_issue_hs;
            r_rej_valid    <= w_issue_hs && !issue_accept_i;
            if (w_cmd_hs) begin
                r_instr <= cmd_instr_i;
                r_rs    <= cmd_rs_i;
                r_kill  <= cmd_kill_i;
            end
            if (w_issue_hs) begin
                r_writeback   <= issue_writeback_i;
                r_commit_id   <= r_next_id;
                r_commit_kill <= r_kill || !issue_accept_i;
                r_next_id     <= r_next_id + 1'b1;
                r_issued_cnt  <= r_issued_cnt + 16'd1;
            end
        end
    end

    // One-hot set/clear masks so a commit and a result on different IDs both land
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_set)     w_set_mask[r_next_id]   = 1'b1;
        if (w_res_hit) w_clr_mask[result_id_i] = 1'b1;
    end

    // Scoreboard, result forwarding, sticky error and retire counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending     <= '0;
            r_outstanding <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_data    <= '0;
            r_rsp_rd      <= '0;
            r_rsp_we      <= 1'b0;
            r_err         <= 1'b0;
            r_retired_cnt <= '0;
        end else begin
            r_pending     <= (r_pending & ~w_clr_mask) | w_set_mask;
            r_outstanding <= r_outstanding + CNT_W'(w_set) - CNT_W'(w_res_hit);
            r_rsp_valid   <= w_res_hit;
            if (w_res_hit) begin
                r_rsp_id      <= result_id_i;
                r_rsp_data    <= result_data_i;
                r_rsp_rd      <= result_rd_i;
                r_rsp_we      <= result_we_i;
                r_retired_cnt <= r_retired_cnt + 16'd1;
            end
            if (w_res_miss) r_err <= 1'b1;
        end
    end

    assign issue_instr_o  = r_instr;
    assign issue_id_o     = r_next_id;
    assign issue_rs_o     = r_rs;
    assign commit_valid_o = r_commit_valid;
    assign commit_id_o    = r_commit_id;
    assign commit_kill_o  = r_commit_kill;
    assign result_ready_o = r_active;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_id_o       = r_rsp_id;
    assign rsp_data_o     = r_rsp_data;
    assign rsp_rd_o       = r_rsp_rd;
    assign rsp_we_o       = r_rsp_we;
    assign rej_valid_o    = r_rej_valid;
    assign err_o          = r_err;
    assign issued_cnt_o   = r_issued_cnt;
    assign retired_cnt_o  = r_retired_cnt;

endmodule
